// File: rtl/switch_nport.sv
// N-port address switch: routes (addr, data) into one of NPORTS per-channel FIFOs
// chosen by the top address bits, with backpressure or drop-on-full input behaviour.
module switch_nport #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int NPORTS       = 4,
  parameter int DEPTH        = 4,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     vld,
  output logic                     in_rdy,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        data,
  output logic [NPORTS-1:0]        out_vld,
  input  logic [NPORTS-1:0]        out_rdy,
  output logic [NPORTS*ADDR_W-1:0] out_addr,
  output logic [NPORTS*DATA_W-1:0] out_data,
  output logic [15:0]              drop_cnt
);

  localparam int  SEL_W   = $clog2(NPORTS);
  localparam int  IDX_W   = $clog2(DEPTH);
  localparam int  PTR_W   = IDX_W + 1;
  localparam int  ENTRY_W = ADDR_W + DATA_W;
  localparam bit  DROP    = (DROP_ON_FULL != 0);

  logic [SEL_W-1:0]  sel;
  logic [NPORTS-1:0] full;
  logic [NPORTS-1:0] empty;
  logic              wr_en;
  logic              drop;

  assign sel    = addr[ADDR_W-1 -: SEL_W];
  assign in_rdy = DROP ? 1'b1 : !full[sel];
  assign wr_en  = vld && !full[sel];
  assign drop   = DROP && vld && full[sel];

  // Saturating discard counter; only ever moves in drop-on-full mode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_ch
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    assign push     = wr_en && (sel == SEL_W'(i));
    assign pop      = out_vld[i] && out_rdy[i];
    assign empty[i] = (wr_ptr == rd_ptr);
    // Full when the index bits match but the wrap bits differ.
    assign full[i]  = (wr_ptr == (rd_ptr ^ {1'b1, {(PTR_W-1){1'b0}}}));

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          mem[k] <= '0;
        end
      end else begin
        if (push) begin
          mem[wr_ptr[IDX_W-1:0]] <= {addr, data};
          wr_ptr                 <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end

    assign head                         = mem[rd_ptr[IDX_W-1:0]];
    assign out_vld[i]                   = !empty[i];
    assign out_addr[i*ADDR_W +: ADDR_W] = head[ENTRY_W-1 -: ADDR_W];
    assign out_data[i*DATA_W +: DATA_W] = head[DATA_W-1:0];
  end

endmodule

// File: tb/tb_switch_nport.sv
// Bench for switch_nport: one backpressure instance and one drop-on-full instance
// driven with identical stimulus and checked against a per-channel queue model.
module tb_switch_nport;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int NPORTS = 4;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        vld;
  logic [7:0]  addr;
  logic [15:0] data;
  logic [3:0]  out_rdy;

  logic        in_rdy_a, in_rdy_b;
  logic [3:0]  out_vld_a, out_vld_b;
  logic [31:0] out_addr_a, out_addr_b;
  logic [63:0] out_data_a, out_data_b;
  logic [15:0] drop_a, drop_b;

  int checks = 0;
  int errors = 0;

  logic [23:0] sbq [4][$];
  int          dropModel = 0;
  bit          accepted  = 1'b0;

  typedef struct {
    logic        v;
    logic [7:0]  a;
    logic [15:0] d;
    logic [3:0]  r;
    logic        expRdy;
    logic [15:0] expDrop;
  } vec_t;

  vec_t tbl [21];

  always #5 clk = ~clk;

  switch_nport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPORTS(NPORTS), .DEPTH(DEPTH), .DROP_ON_FULL(0)) dutA (
    .clk(clk), .rstn(rstn), .vld(vld), .in_rdy(in_rdy_a), .addr(addr), .data(data),
    .out_vld(out_vld_a), .out_rdy(out_rdy), .out_addr(out_addr_a), .out_data(out_data_a),
    .drop_cnt(drop_a)
  );

  switch_nport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPORTS(NPORTS), .DEPTH(DEPTH), .DROP_ON_FULL(1)) dutB (
    .clk(clk), .rstn(rstn), .vld(vld), .in_rdy(in_rdy_b), .addr(addr), .data(data),
    .out_vld(out_vld_b), .out_rdy(out_rdy), .out_addr(out_addr_b), .out_data(out_data_b),
    .drop_cnt(drop_b)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [15:0] d, input logic [3:0] r);
    @(posedge clk);
    #1;
    vld     = v;
    addr    = a;
    data    = d;
    out_rdy = r;
  endtask

  // Model step on the falling edge: compare current DUT state, then advance the
  // queues to what the next rising edge should leave behind.
  always @(negedge clk) begin : monitor
    logic [1:0] s;
    bit         expRdy;
    if (!rstn) begin
      accepted = 1'b0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        checkOutput($sformatf("out_vld_a[%0d]", i), 64'(out_vld_a[i]), 64'(sbq[i].size() > 0));
        checkOutput($sformatf("out_vld_b[%0d]", i), 64'(out_vld_b[i]), 64'(sbq[i].size() > 0));
        if (sbq[i].size() > 0) begin
          checkOutput($sformatf("out_addr_a[%0d]", i), 64'(out_addr_a[i*8 +: 8]), 64'(sbq[i][0][23:16]));
          checkOutput($sformatf("out_data_a[%0d]", i), 64'(out_data_a[i*16 +: 16]), 64'(sbq[i][0][15:0]));
          checkOutput($sformatf("out_addr_b[%0d]", i), 64'(out_addr_b[i*8 +: 8]), 64'(sbq[i][0][23:16]));
          checkOutput($sformatf("out_data_b[%0d]", i), 64'(out_data_b[i*16 +: 16]), 64'(sbq[i][0][15:0]));
        end
      end
      checkOutput("drop_cnt_a", 64'(drop_a), 64'd0);
      checkOutput("drop_cnt_b", 64'(drop_b), 64'(dropModel));
      s      = addr[7:6];
      expRdy = (sbq[s].size() < DEPTH);
      checkOutput("in_rdy_a", 64'(in_rdy_a), 64'(expRdy));
      checkOutput("in_rdy_b", 64'(in_rdy_b), 64'd1);
      accepted = vld && expRdy;
      if (vld && !expRdy && dropModel < 65535) dropModel++;
      for (int i = 0; i < NPORTS; i++) begin
        if (out_rdy[i] && sbq[i].size() > 0) void'(sbq[i].pop_front());
      end
      if (accepted) sbq[s].push_back({addr, data});
    end
  end

  initial begin
    int  got;
    int  cycles;
    bit  acc;

    tbl[0]  = '{1'b1, 8'h10, 16'h1111, 4'h0, 1'b1, 16'd0};
    tbl[1]  = '{1'b1, 8'h50, 16'h2222, 4'h0, 1'b1, 16'd0};
    tbl[2]  = '{1'b1, 8'h90, 16'h3333, 4'h0, 1'b1, 16'd0};
    tbl[3]  = '{1'b1, 8'hD0, 16'h4444, 4'h0, 1'b1, 16'd0};
    tbl[4]  = '{1'b0, 8'h00, 16'h0000, 4'hF, 1'b1, 16'd0};
    tbl[5]  = '{1'b0, 8'h00, 16'h0000, 4'h0, 1'b1, 16'd0};
    tbl[6]  = '{1'b1, 8'h80, 16'hA000, 4'h0, 1'b1, 16'd0};
    tbl[7]  = '{1'b1, 8'h81, 16'hA001, 4'h0, 1'b1, 16'd0};
    tbl[8]  = '{1'b1, 8'h82, 16'hA002, 4'h0, 1'b1, 16'd0};
    tbl[9]  = '{1'b1, 8'h83, 16'hA003, 4'h0, 1'b1, 16'd0};
    tbl[10] = '{1'b1, 8'h84, 16'hA004, 4'h0, 1'b0, 16'd0};
    tbl[11] = '{1'b1, 8'h00, 16'hB000, 4'h0, 1'b1, 16'd1};
    tbl[12] = '{1'b1, 8'h85, 16'hA005, 4'h0, 1'b0, 16'd1};
    tbl[13] = '{1'b0, 8'h80, 16'h0000, 4'h0, 1'b0, 16'd2};
    tbl[14] = '{1'b1, 8'h86, 16'hA006, 4'h4, 1'b0, 16'd2};
    tbl[15] = '{1'b1, 8'h86, 16'hA006, 4'h0, 1'b1, 16'd3};
    tbl[16] = '{1'b0, 8'h00, 16'h0000, 4'hF, 1'b1, 16'd3};
    tbl[17] = '{1'b0, 8'h00, 16'h0000, 4'hF, 1'b1, 16'd3};
    tbl[18] = '{1'b0, 8'h00, 16'h0000, 4'hF, 1'b1, 16'd3};
    tbl[19] = '{1'b0, 8'h00, 16'h0000, 4'hF, 1'b1, 16'd3};
    tbl[20] = '{1'b0, 8'h00, 16'h0000, 4'hF, 1'b1, 16'd3};

    rstn    = 1'b0;
    vld     = 1'b0;
    addr    = '0;
    data    = '0;
    out_rdy = '0;
    #12;
    checkOutput("reset out_vld_a", 64'(out_vld_a), 64'd0);
    checkOutput("reset out_vld_b", 64'(out_vld_b), 64'd0);
    checkOutput("reset out_addr_a", 64'(out_addr_a), 64'd0);
    checkOutput("reset out_data_a", out_data_a, 64'd0);
    checkOutput("reset out_data_b", out_data_b, 64'd0);
    checkOutput("reset drop_cnt_b", 64'(drop_b), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Directed table: single writes, channel fill, drop counting, pop+push on full.
    for (int k = 0; k < 21; k++) begin
      applyStimulus(tbl[k].v, tbl[k].a, tbl[k].d, tbl[k].r);
      #1;
      checkOutput($sformatf("row%0d in_rdy_a", k), 64'(in_rdy_a), 64'(tbl[k].expRdy));
      checkOutput($sformatf("row%0d drop_cnt_b", k), 64'(drop_b), 64'(tbl[k].expDrop));
    end

    // Three fill/drain rounds on channel 2 with a pop+push collision while full.
    for (int round = 0; round < 3; round++) begin
      for (int k = 0; k < DEPTH; k++) begin
        applyStimulus(1'b1, 8'h80 + 8'(k), 16'hC000 + 16'(round * 16 + k), 4'h0);
      end
      applyStimulus(1'b1, 8'hBF, 16'hCF00 + 16'(round), 4'h4);
      #1;
      checkOutput("full collision in_rdy_a", 64'(in_rdy_a), 64'd0);
      applyStimulus(1'b1, 8'hBF, 16'hCF00 + 16'(round), 4'h0);
      #1;
      checkOutput("after collision in_rdy_a", 64'(in_rdy_a), 64'd1);
      for (int k = 0; k < DEPTH + 1; k++) begin
        applyStimulus(1'b0, 8'h00, 16'h0000, 4'h4);
      end
    end

    // Random traffic with retry until the model reports acceptance.
    got    = 0;
    cycles = 0;
    applyStimulus(1'b1, 8'($urandom), 16'($urandom), 4'($urandom));
    while (got < 1000 && cycles < 20000) begin
      @(negedge clk);
      #1;
      acc = accepted;
      @(posedge clk);
      #1;
      if (acc) begin
        got++;
        addr = 8'($urandom);
        data = 16'($urandom);
      end
      vld     = ($urandom_range(0, 3) != 0);
      out_rdy = 4'($urandom);
      cycles++;
    end
    checkOutput("random accepted count", 64'(got), 64'd1000);
    applyStimulus(1'b0, 8'h00, 16'h0000, 4'hF);
    repeat (DEPTH + 1) applyStimulus(1'b0, 8'h00, 16'h0000, 4'hF);
    checkOutput("random drained out_vld_a", 64'(out_vld_a), 64'd0);

    // Reset while three entries sit in channel 1.
    applyStimulus(1'b1, 8'h40, 16'hD000, 4'h0);
    applyStimulus(1'b1, 8'h41, 16'hD001, 4'h0);
    applyStimulus(1'b1, 8'h42, 16'hD002, 4'h0);
    applyStimulus(1'b0, 8'h00, 16'h0000, 4'h0);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    vld  = 1'b0;
    for (int i = 0; i < NPORTS; i++) sbq[i].delete();
    dropModel = 0;
    #1;
    checkOutput("async reset out_vld_a", 64'(out_vld_a), 64'd0);
    checkOutput("async reset out_vld_b", 64'(out_vld_b), 64'd0);
    checkOutput("async reset drop_cnt_b", 64'(drop_b), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) applyStimulus(1'b0, 8'h40, 16'h0000, 4'h0);
    checkOutput("post reset out_vld_a", 64'(out_vld_a), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_nport.md
Name: switch_nport

Overview:
- Parametrised successor to the two-port address switch.
- Routes each valid input transaction (addr, data) to one of NPORTS output channels, selected by the top address bits.
- Each channel has a DEPTH-entry FIFO and a valid/ready output handshake.
- Input backpressure or drop-on-full behaviour is chosen by parameter; dropped transactions are counted for the testbench scoreboard.

Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 16, data width in bits.
- NPORTS, 4, number of output channels; power of two, 2..16.
- DEPTH, 4, entries per channel FIFO; power of two, at least 2.
- DROP_ON_FULL, 0, 0 = backpressure through in_rdy; 1 = in_rdy held 1 and full-channel writes are discarded and counted.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- vld  input  1  input transaction valid.
- in_rdy  output  1  input ready; transfer occurs when vld && in_rdy.
- addr  input  ADDR_W  destination address.
- data  input  DATA_W  payload.
- out_vld  output  NPORTS  per-channel head-of-FIFO valid.
- out_rdy  input  NPORTS  per-channel consumer ready.
- out_addr  output  NPORTS*ADDR_W  per-channel head address; channel i in bits [i*ADDR_W +: ADDR_W].
- out_data  output  NPORTS*DATA_W  per-channel head data, packed the same way.
- drop_cnt  output  16  saturating count of discarded transactions.

Behaviour:
- Reset, asynchronous on rstn low: all FIFO pointers and counts = 0, out_vld = 0, out_addr = 0, out_data = 0, drop_cnt = 0. in_rdy = 1 once rstn is high.
- Routing: sel = addr[ADDR_W-1 -: log2(NPORTS)]. With NPORTS = 2 this matches the legacy split: addr < 0x80 goes to channel 0, otherwise channel 1.
- in_rdy:
  - DROP_ON_FULL = 0: in_rdy = !full[sel]. Combinational from addr; does not depend on vld.
  - DROP_ON_FULL = 1: in_rdy = 1.
- Write: vld && in_rdy && !full[sel] pushes {addr, data} into FIFO[sel].
- Drop: vld && full[sel] with DROP_ON_FULL = 1 discards the transaction and increments drop_cnt. drop_cnt saturates at 0xFFFF.
- Latency: a transaction written in cycle N appears on out_vld/out_addr/out_data of its channel in cycle N+1 (registered count, no combinational bypass).
- Pop: out_vld[i] && out_rdy[i] pops channel i. The next entry is presented in the following cycle. out_rdy on an empty channel is ignored.
- Output stability: while out_vld[i] && !out_rdy[i], out_addr and out_data for that channel are held stable.
- Empty channel: out_vld = 0; out_addr/out_data hold their last values. Checkers treat them as don't-care.
- Push and pop on the same channel in the same cycle:
  - Not full: both take effect, count unchanged.
  - Full: pop only. The push is refused (in_rdy = 0) or dropped (DROP_ON_FULL = 1); no pass-through.
- Pointer wrap: pointers are log2(DEPTH)+1 bits with a wrap bit. full = (wr_ptr == rd_ptr with MSB inverted); empty = (wr_ptr == rd_ptr).
- Ordering: FIFO order is preserved per channel; there is no ordering between channels.
- Reset mid-operation: all buffered entries are lost and out_vld falls to 0 immediately (asynchronous). drop_cnt is cleared.
- X-safety: vld = 0 never writes or counts, regardless of the values on addr and data.

Test Plan:
- Reset then single writes: addr 0x10/0x50/0x90/0xD0 with data 0x1111..0x4444 (NPORTS = 4) -> each out_vld[0..3] rises one cycle later with the matching addr/data; drop_cnt = 0.
- Fill channel 2 with out_rdy = 0 (DROP_ON_FULL = 0): 4 writes to addr 0x80..0x83 accepted, 5th sees in_rdy = 0. A write to addr 0x00 in the same state is accepted.
- Same fill with DROP_ON_FULL = 1: 6 writes to channel 2 -> in_rdy stays 1, drop_cnt = 2, channel 2 drains exactly the first 4 in order.
- Full channel with simultaneous pop and push, out_rdy[2] = 1: head pops, push refused. The next cycle accepts the push; FIFO order is intact across pointer wrap after 3 full fill/drain rounds.
- Randomised traffic, 1000 transactions, random out_rdy: scoreboard per channel matches in order; no loss when DROP_ON_FULL = 0.
- Assert rstn low with 3 entries buffered: out_vld = 0 asynchronously. After release, no stale data appears and drop_cnt = 0.
